fetch_pc_gen: RTL and testbench

//  Parametrised fetch-stage next-PC generator; successor to the basic PC register.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_pc_gen_if.sv | 32 +++
 rtl/ras_stack.sv | 67 ++++++
 rtl/fetch_pc_gen.sv | 110 +++++++++++
 tb/tb_fetch_pc_gen.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage next-PC generator.
// States, redirect causes and default widths used by fetch_pc_gen and its RAS.
package fetch_pkg;

  localparam int unsigned DefaultXlen       = 32;
  localparam int unsigned DefaultInstrBytes = 4;
  localparam int unsigned DefaultRasDepth   = 4;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } fetch_state_t;

  typedef enum logic [1:0] {
    RdNone,
    RdTrap,
    RdBranch,
    RdRas
  } redirect_cause_t;

  function automatic logic is_redirect(redirect_cause_t cause);
    return cause != RdNone;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-to-IMEM request bundle: fetch PC, valid/ready handshake and F-stage status flags.
// The PC generator drives it through the master modport; IMEM / F-stage logic uses slave.
interface fetch_pc_gen_if #(
  parameter int unsigned XLEN = 32
);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_plus_f;
  logic            fetch_valid;
  logic            imem_ready;
  logic            redirect_f;
  logic            misalign_f;

  modport master (
    output pc_f,
    output pc_plus_f,
    output fetch_valid,
    output redirect_f,
    output misalign_f,
    input  imem_ready
  );

  modport slave (
    input  pc_f,
    input  pc_plus_f,
    input  fetch_valid,
    input  redirect_f,
    input  misalign_f,
    output imem_ready
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack with a top pointer and saturating occupancy count.
// Overflow overwrites the oldest entry; push+pop together replaces the top in place.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_pop;
  logic            wr_en;
  logic [PtrW-1:0] wr_ptr;

  always_comb begin
    do_pop = pop && (cnt_q != '0);
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (push && do_pop) begin
      // Return consumed and a new call recorded: overwrite the top, depth unchanged.
      wr_en = 1'b1;
    end else if (push) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_q + 1'b1;
      ptr_d  = ptr_q + 1'b1;
      if (cnt_q != CntW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (do_pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= push_addr;
    end
  end

  assign top   = mem_q[ptr_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: trap > E-branch > RAS return > sequential, plus boot/run/halt.
// Define FETCH_PC_GEN_RAS_EN to build the return-address stack and enable RAS redirects.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = DefaultXlen,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INSTR_BYTES  = DefaultInstrBytes,
  parameter int unsigned     RAS_DEPTH    = DefaultRasDepth
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            halt_req,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  fetch_pc_gen_if.master  imem,
  output logic            ras_empty
);

  localparam int unsigned OffW = $clog2(INSTR_BYTES);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  redirect_cause_t cause;
  logic [XLEN-1:0] ras_top;
  logic            run;
  logic            halted;

  assign run    = (state_q == StRun);
  assign halted = (state_q == StHalt);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (halt_req && !trap_valid) state_d = StHalt;
      StHalt:  if (trap_valid) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  // Redirects bypass stall and IMEM backpressure; only the sequential step honours them.
  always_comb begin
    cause = RdNone;
    pc_d  = pc_q;
    if ((run || halted) && trap_valid) begin
      cause = RdTrap;
      pc_d  = trap_pc;
    end else if (run && pc_src_e) begin
      cause = RdBranch;
      pc_d  = pc_target_e;
    end else if (run && ras_pop && !ras_empty) begin
      cause = RdRas;
      pc_d  = ras_top;
    end else if (run && imem.imem_ready && !stall_f) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_PC_GEN_RAS_EN
  logic ras_push_en;
  logic ras_pop_en;

  // Traps leave the stack untouched; a pop only counts when it actually redirects.
  assign ras_push_en = run && ras_push && !trap_valid;
  assign ras_pop_en  = (cause == RdRas);

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push_en),
    .pop       (ras_pop_en),
    .push_addr (ras_push_addr),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras;

  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign unused_ras = ras_push ^ (^ras_push_addr) ^ RAS_DEPTH[0];
`endif

  assign imem.pc_f        = pc_q;
  assign imem.pc_plus_f   = pc_q + XLEN'(INSTR_BYTES);
  assign imem.fetch_valid = run;
  assign imem.misalign_f  = |pc_q[OffW-1:0];
  assign imem.redirect_f  = is_redirect(cause) && !rst;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus a randomized run
// compared against a queue-based reference model of PC selection and the return stack.
module tb_fetch_pc_gen;

  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] RV    = 32'h100;
  localparam int unsigned IB    = 4;
  localparam int unsigned DEPTH = 4;
`ifdef FETCH_PC_GEN_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        halt_req;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        ras_push;
  logic [31:0] ras_push_addr;
  logic        ras_pop;
  logic        ras_empty;

  fetch_pc_gen_if #(.XLEN(XLEN)) imem ();

  fetch_pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .INSTR_BYTES  (IB),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_f       (stall_f),
    .halt_req      (halt_req),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .pc_src_e      (pc_src_e),
    .pc_target_e   (pc_target_e),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .ras_pop       (ras_pop),
    .imem          (imem),
    .ras_empty     (ras_empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = boot, 1 = running, 2 = halted; stack as a queue (back = top).
  int          m_mode = 0;
  logic [31:0] m_pc   = RV;
  logic [31:0] m_ras[$];

  function automatic bit exp_redirect();
    if (rst) return 1'b0;
    if (m_mode != 0 && trap_valid) return 1'b1;
    if (m_mode == 1 && pc_src_e) return 1'b1;
    if (m_mode == 1 && RasEn && ras_pop && m_ras.size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    logic [31:0] npc;
    int          nmode;
    bit          running, pop_take, push_ok;
    if (rst) begin
      m_pc   = RV;
      m_mode = 0;
      m_ras.delete();
    end else begin
      npc      = m_pc;
      nmode    = m_mode;
      running  = (m_mode == 1);
      pop_take = RasEn && running && !trap_valid && !pc_src_e && ras_pop && m_ras.size() > 0;
      push_ok  = RasEn && running && ras_push && !trap_valid;
      if (m_mode != 0 && trap_valid) npc = trap_pc;
      else if (running && pc_src_e) npc = pc_target_e;
      else if (pop_take) npc = m_ras[m_ras.size()-1];
      else if (running && imem.imem_ready && !stall_f) npc = m_pc + IB;
      if (pop_take && push_ok) m_ras[m_ras.size()-1] = ras_push_addr;
      else if (pop_take) void'(m_ras.pop_back());
      else if (push_ok) begin
        m_ras.push_back(ras_push_addr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      if (m_mode == 0) nmode = 1;
      else if (m_mode == 1 && halt_req && !trap_valid) nmode = 2;
      else if (m_mode == 2 && trap_valid) nmode = 1;
      m_pc   = npc;
      m_mode = nmode;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall_f = 1'b0; halt_req = 1'b0; trap_valid = 1'b0; trap_pc = '0;
    pc_src_e = 1'b0; pc_target_e = '0; ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
    imem.imem_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h100; exp_seq[1] = 32'h104; exp_seq[2] = 32'h108;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total += 4;
    if (imem.pc_f !== 32'h100) begin
      bad++; $display("FAIL reset_pc: got %h want %h", imem.pc_f, 32'h100);
    end
    if (imem.fetch_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", imem.fetch_valid);
    end
    if (ras_empty !== 1'b1) begin
      bad++; $display("FAIL reset_ras_empty: got %b want 1", ras_empty);
    end
    if (imem.redirect_f !== 1'b0) begin
      bad++; $display("FAIL reset_redirect: got %b want 0", imem.redirect_f);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total += 2;
      if (imem.pc_f !== exp_seq[i]) begin
        bad++; $display("FAIL boot_seq%0d_pc: got %h want %h", i, imem.pc_f, exp_seq[i]);
      end
      if (imem.fetch_valid !== 1'b1) begin
        bad++; $display("FAIL boot_seq%0d_valid: got %b want 1", i, imem.fetch_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    pc_src_e = 1'b1; pc_target_e = 32'h200;
    tick();
    pc_src_e = 1'b0;
    imem.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem.pc_f !== 32'h200) begin
        bad++; $display("FAIL notready%0d_pc: got %h want %h", i, imem.pc_f, 32'h200);
      end
    end
    imem.imem_ready = 1'b1;
    tick();
    total++;
    if (imem.pc_f !== 32'h204) begin
      bad++; $display("FAIL ready_advance_pc: got %h want %h", imem.pc_f, 32'h204);
    end
    stall_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem.pc_f !== 32'h204) begin
        bad++; $display("FAIL stall%0d_pc: got %h want %h", i, imem.pc_f, 32'h204);
      end
    end
    stall_f = 1'b0;
    tick();
    total++;
    if (imem.pc_f !== 32'h208) begin
      bad++; $display("FAIL unstall_pc: got %h want %h", imem.pc_f, 32'h208);
    end
  endtask

  task automatic test_priority();
    stall_f = 1'b1; imem.imem_ready = 1'b0;
    trap_valid = 1'b1; trap_pc = 32'h800;
    pc_src_e = 1'b1; pc_target_e = 32'h400;
    #1;
    total++;
    if (imem.redirect_f !== 1'b1) begin
      bad++; $display("FAIL prio_redirect: got %b want 1", imem.redirect_f);
    end
    tick();
    total += 2;
    if (imem.pc_f !== 32'h800) begin
      bad++; $display("FAIL prio_pc: got %h want %h", imem.pc_f, 32'h800);
    end
    if (imem.fetch_valid !== 1'b1) begin
      bad++; $display("FAIL prio_still_run: got %b want 1", imem.fetch_valid);
    end
    idle_inputs();
  endtask

  task automatic test_wrap_misalign();
    pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    tick();
    pc_src_e = 1'b0;
    total += 2;
    if (imem.pc_plus_f !== 32'h0) begin
      bad++; $display("FAIL wrap_plus: got %h want %h", imem.pc_plus_f, 32'h0);
    end
    if (imem.misalign_f !== 1'b0) begin
      bad++; $display("FAIL aligned_flag: got %b want 0", imem.misalign_f);
    end
    tick();
    total++;
    if (imem.pc_f !== 32'h0) begin
      bad++; $display("FAIL wrap_pc: got %h want %h", imem.pc_f, 32'h0);
    end
    pc_src_e = 1'b1; pc_target_e = 32'h402;
    tick();
    total += 2;
    if (imem.pc_f !== 32'h402) begin
      bad++; $display("FAIL misalign_pc: got %h want %h", imem.pc_f, 32'h402);
    end
    if (imem.misalign_f !== 1'b1) begin
      bad++; $display("FAIL misalign_flag: got %b want 1", imem.misalign_f);
    end
    pc_target_e = 32'h300;
    tick();
    pc_src_e = 1'b0;
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    total += 2;
    if (imem.fetch_valid !== 1'b0) begin
      bad++; $display("FAIL halt_valid: got %b want 0", imem.fetch_valid);
    end
    if (imem.pc_f !== 32'h304) begin
      bad++; $display("FAIL halt_entry_pc: got %h want %h", imem.pc_f, 32'h304);
    end
    // Branches and pops are not redirects while halted.
    pc_src_e = 1'b1; pc_target_e = 32'h600; ras_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (imem.redirect_f !== 1'b0) begin
        bad++; $display("FAIL halt%0d_redirect: got %b want 0", i, imem.redirect_f);
      end
      tick();
      total++;
      if (imem.pc_f !== 32'h304) begin
        bad++; $display("FAIL halt%0d_pc: got %h want %h", i, imem.pc_f, 32'h304);
      end
    end
    idle_inputs();
    trap_valid = 1'b1; trap_pc = 32'h80;
    #1;
    total++;
    if (imem.redirect_f !== 1'b1) begin
      bad++; $display("FAIL wake_redirect: got %b want 1", imem.redirect_f);
    end
    tick();
    trap_valid = 1'b0;
    total += 2;
    if (imem.pc_f !== 32'h80) begin
      bad++; $display("FAIL wake_pc: got %h want %h", imem.pc_f, 32'h80);
    end
    if (imem.fetch_valid !== 1'b1) begin
      bad++; $display("FAIL wake_valid: got %b want 1", imem.fetch_valid);
    end
  endtask

  task automatic test_ras();
`ifdef FETCH_PC_GEN_RAS_EN
    logic [31:0] pops [4];
    logic [31:0] mix  [3];
    pops[0] = 32'hE0; pops[1] = 32'hD0; pops[2] = 32'hC0; pops[3] = 32'hB0;
    mix[0] = 32'h22; mix[1] = 32'h33; mix[2] = 32'h11;
    for (int i = 0; i < 5; i++) begin
      ras_push = 1'b1; ras_push_addr = 32'hA0 + 32'(i) * 32'h10;
      tick();
    end
    ras_push = 1'b0;
    total++;
    if (ras_empty !== 1'b0) begin
      bad++; $display("FAIL ras_full_empty: got %b want 0", ras_empty);
    end
    ras_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (imem.redirect_f !== 1'b1) begin
        bad++; $display("FAIL pop%0d_redirect: got %b want 1", i, imem.redirect_f);
      end
      tick();
      total++;
      if (imem.pc_f !== pops[i]) begin
        bad++; $display("FAIL pop%0d_pc: got %h want %h", i, imem.pc_f, pops[i]);
      end
    end
    #1;
    total += 2;
    if (imem.redirect_f !== 1'b0) begin
      bad++; $display("FAIL pop_empty_redirect: got %b want 0", imem.redirect_f);
    end
    if (ras_empty !== 1'b1) begin
      bad++; $display("FAIL pop_empty_flag: got %b want 1", ras_empty);
    end
    tick();
    total++;
    if (imem.pc_f !== 32'hB4) begin
      bad++; $display("FAIL pop_empty_pc: got %h want %h", imem.pc_f, 32'hB4);
    end
    ras_pop = 1'b0;
    ras_push = 1'b1; ras_push_addr = 32'h11; tick();
    ras_push_addr = 32'h22; tick();
    ras_pop = 1'b1; ras_push_addr = 32'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      ras_push = 1'b0;
      total++;
      if (imem.pc_f !== mix[i]) begin
        bad++; $display("FAIL pushpop%0d_pc: got %h want %h", i, imem.pc_f, mix[i]);
      end
    end
    total++;
    if (ras_empty !== 1'b1) begin
      bad++; $display("FAIL pushpop_empty: got %b want 1", ras_empty);
    end
`else
    logic [31:0] prev;
    ras_push = 1'b1; ras_push_addr = 32'h40;
    tick();
    ras_push = 1'b0;
    total++;
    if (ras_empty !== 1'b1) begin
      bad++; $display("FAIL noras_empty: got %b want 1", ras_empty);
    end
    prev = imem.pc_f;
    ras_pop = 1'b1;
    #1;
    total++;
    if (imem.redirect_f !== 1'b0) begin
      bad++; $display("FAIL noras_redirect: got %b want 0", imem.redirect_f);
    end
    tick();
    total++;
    if (imem.pc_f !== m_pc) begin
      bad++; $display("FAIL noras_pc: got %h want %h (from %h)", imem.pc_f, m_pc, prev);
    end
`endif
    idle_inputs();
    pc_src_e = 1'b1; pc_target_e = 32'h1000;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit exp_r;
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(63) == 0);
      trap_valid      = ($urandom_range(15) == 0);
      halt_req        = ($urandom_range(15) == 0);
      pc_src_e        = ($urandom_range(7) == 0);
      ras_push        = ($urandom_range(3) == 0);
      ras_pop         = ($urandom_range(3) == 0);
      stall_f         = ($urandom_range(4) == 0);
      imem.imem_ready = ($urandom_range(3) != 0);
      trap_pc         = $urandom & 32'hFFFF_FFFC;
      pc_target_e     = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      ras_push_addr   = $urandom & 32'hFFFF_FFFC;
      #1;
      exp_r = exp_redirect();
      total++;
      if (imem.redirect_f !== exp_r) begin
        bad++; $display("FAIL rnd%0d_redirect: got %b want %b", i, imem.redirect_f, exp_r);
      end
      tick();
      total += 5;
      if (imem.pc_f !== m_pc) begin
        bad++; $display("FAIL rnd%0d_pc: got %h want %h", i, imem.pc_f, m_pc);
      end
      if (imem.pc_plus_f !== m_pc + IB) begin
        bad++; $display("FAIL rnd%0d_plus: got %h want %h", i, imem.pc_plus_f, m_pc + IB);
      end
      if (imem.fetch_valid !== (m_mode == 1)) begin
        bad++; $display("FAIL rnd%0d_valid: got %b want %b", i, imem.fetch_valid, m_mode == 1);
      end
      if (imem.misalign_f !== (m_pc[1:0] != 2'b00)) begin
        bad++; $display("FAIL rnd%0d_misalign: got %b want %b", i, imem.misalign_f,
                        m_pc[1:0] != 2'b00);
      end
      if (ras_empty !== (m_ras.size() == 0)) begin
        bad++; $display("FAIL rnd%0d_ras_empty: got %b want %b", i, ras_empty,
                        m_ras.size() == 0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_backpressure();
    test_priority();
    test_wrap_misalign();
    test_halt();
    test_ras();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
